vga_indexed_display: RTL and testbench

VGA_INDEXED_DISPLAY -- requirements
Module: vga_indexed_display

---
 rtl/vga_indexed_display.sv | 212 +++++++++++++++++++++
 tb/tb_vga_indexed_display.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_indexed_display.sv
// Indexed-colour VGA scanout: timing counters, double-buffered framebuffer addressing,
// 24-bit palette lookup and a frame-latched square cursor, all aligned through a two-stage pipeline.
module vga_indexed_display #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned AW       = 20,
    parameter int unsigned CW       = 11,
    parameter int unsigned CUR_SIZE = 8
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    input  logic             iPAL_WE,
    input  logic [IDX_W-1:0] iPAL_ADDR,
    input  logic [23:0]      iPAL_DATA,
    input  logic             iBUF_SEL,
    input  logic             iCUR_EN,
    input  logic [CW-1:0]    iCUR_X,
    input  logic [CW-1:0]    iCUR_Y,
    input  logic [23:0]      iCUR_COLOR,
    output logic [AW-1:0]    oFB_ADDR,
    input  logic [IDX_W-1:0] iFB_DATA,
    output logic             oHS,
    output logic             oVS,
    output logic             oBLANK_n,
    output logic [7:0]       b_data,
    output logic [7:0]       g_data,
    output logic [7:0]       r_data,
    output logic             oFRAME_START,
    output logic             oBUF_ACTIVE
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW        = $clog2(H_TOTAL);
    localparam int unsigned VW        = $clog2(V_TOTAL);
    localparam int unsigned PW        = $clog2(H_ACTIVE * V_ACTIVE + 1);
    localparam int unsigned XW        = CW + 1;
    localparam int unsigned KW0       = (XW > HW) ? XW : HW;
    localparam int unsigned KW        = (KW0 > VW) ? KW0 : VW;
    localparam int unsigned PAL_DEPTH = 1 << IDX_W;
    localparam logic [AW-1:0] BUF_BASE = AW'(H_ACTIVE * V_ACTIVE);

    // Scan state
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [PW-1:0] p_q, p_d;
    logic          buf_q, buf_d;
    logic [AW-1:0] addr_last_q, addr_last_d;

    // Cursor state latched once per frame
    logic          cur_en_q, cur_en_d;
    logic [CW-1:0] cur_x_q, cur_x_d;
    logic [CW-1:0] cur_y_q, cur_y_d;
    logic [23:0]   cur_color_q, cur_color_d;

    // Pipeline stage 1 and output stage
    logic        vis1_q, vis1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        hit1_q, hit1_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic [23:0] rgb_q, rgb_d;
    logic        fs_q, fs_d;

    logic [23:0] pal_mem [PAL_DEPTH];

    logic          line_end_c;
    logic          frame_end_c;
    logic          visible_c;
    logic          hs_c;
    logic          vs_c;
    logic          hit_c;
    logic [AW-1:0] addr_now_c;
    logic [23:0]   pal_rd_c;
    logic [KW-1:0] hk_c, vk_c, x_lo_c, x_hi_c, y_lo_c, y_hi_c;

    assign line_end_c  = (h_q == HW'(H_TOTAL - 1));
    assign frame_end_c = line_end_c && (v_q == VW'(V_TOTAL - 1));
    assign visible_c   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hs_c = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_c = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));

    // Buffer base is a constant selected by a mux, so the address path has no multiplier
    assign addr_now_c = (buf_q ? BUF_BASE : '0) + AW'(p_q);
    assign oFB_ADDR   = visible_c ? addr_now_c : addr_last_q;

    // Cursor bounds extended by one bit so X+CUR_SIZE clips instead of wrapping
    assign hk_c   = KW'(h_q);
    assign vk_c   = KW'(v_q);
    assign x_lo_c = KW'(cur_x_q);
    assign y_lo_c = KW'(cur_y_q);
    assign x_hi_c = KW'(XW'(cur_x_q) + XW'(CUR_SIZE));
    assign y_hi_c = KW'(XW'(cur_y_q) + XW'(CUR_SIZE));
    assign hit_c  = cur_en_q && (hk_c >= x_lo_c) && (hk_c < x_hi_c)
                             && (vk_c >= y_lo_c) && (vk_c < y_hi_c);

    // Palette: write-first is avoided, a same-cycle read sees the old entry
    always_ff @(posedge iVGA_CLK) begin
        if (iPAL_WE) begin
            pal_mem[iPAL_ADDR] <= iPAL_DATA;
        end
    end

    assign pal_rd_c = pal_mem[iFB_DATA];

    // Counter advance and end-of-frame latch of buffer select and cursor
    always_comb begin
        h_d         = h_q + HW'(1);
        v_d         = v_q;
        p_d         = p_q;
        buf_d       = buf_q;
        addr_last_d = addr_last_q;
        cur_en_d    = cur_en_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_color_d = cur_color_q;
        if (visible_c) begin
            p_d         = p_q + PW'(1);
            addr_last_d = addr_now_c;
        end
        if (line_end_c) begin
            h_d = '0;
            v_d = v_q + VW'(1);
            if (frame_end_c) begin
                v_d         = '0;
                p_d         = '0;
                buf_d       = iBUF_SEL;
                cur_en_d    = iCUR_EN;
                cur_x_d     = iCUR_X;
                cur_y_d     = iCUR_Y;
                cur_color_d = iCUR_COLOR;
            end
        end
    end

    // Two-stage pipeline keeping syncs and blank aligned with colour
    always_comb begin
        vis1_d  = visible_c;
        hs1_d   = hs_c;
        vs1_d   = vs_c;
        hit1_d  = hit_c;
        hs_d    = hs1_q;
        vs_d    = vs1_q;
        blank_d = vis1_q;
        fs_d    = frame_end_c;
        rgb_d   = '0;
        if (vis1_q) begin
            rgb_d = hit1_q ? cur_color_q : pal_rd_c;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_q         <= '0;
            v_q         <= '0;
            p_q         <= '0;
            buf_q       <= 1'b0;
            addr_last_q <= '0;
            cur_en_q    <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cur_color_q <= '0;
            vis1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            hit1_q      <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            rgb_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            p_q         <= p_d;
            buf_q       <= buf_d;
            addr_last_q <= addr_last_d;
            cur_en_q    <= cur_en_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_color_q <= cur_color_d;
            vis1_q      <= vis1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            hit1_q      <= hit1_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            rgb_q       <= rgb_d;
            fs_q        <= fs_d;
        end
    end

    assign oHS          = hs_q;
    assign oVS          = vs_q;
    assign oBLANK_n     = blank_q;
    assign b_data       = rgb_q[23:16];
    assign g_data       = rgb_q[15:8];
    assign r_data       = rgb_q[7:0];
    assign oFRAME_START = fs_q;
    assign oBUF_ACTIVE  = buf_q;

endmodule

// File: tb/tb_vga_indexed_display.sv
// Scoreboard bench for vga_indexed_display on a 14x7 timing grid with a 2x2 cursor.
`timescale 1ns/1ps
module tb_vga_indexed_display;

    logic        clk = 1'b0;
    logic        iRST_n;
    logic        iPAL_WE;
    logic [7:0]  iPAL_ADDR;
    logic [23:0] iPAL_DATA;
    logic        iBUF_SEL;
    logic        iCUR_EN;
    logic [10:0] iCUR_X;
    logic [10:0] iCUR_Y;
    logic [23:0] iCUR_COLOR;
    logic [19:0] oFB_ADDR;
    logic [7:0]  iFB_DATA;
    logic        oHS, oVS, oBLANK_n;
    logic [7:0]  b_data, g_data, r_data;
    logic        oFRAME_START, oBUF_ACTIVE;

    always #5 clk = ~clk;

    vga_indexed_display #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .IDX_W(8), .AW(20), .CW(11), .CUR_SIZE(2)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(iRST_n),
        .iPAL_WE(iPAL_WE), .iPAL_ADDR(iPAL_ADDR), .iPAL_DATA(iPAL_DATA),
        .iBUF_SEL(iBUF_SEL), .iCUR_EN(iCUR_EN), .iCUR_X(iCUR_X), .iCUR_Y(iCUR_Y),
        .iCUR_COLOR(iCUR_COLOR), .oFB_ADDR(oFB_ADDR), .iFB_DATA(iFB_DATA),
        .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
        .b_data(b_data), .g_data(g_data), .r_data(r_data),
        .oFRAME_START(oFRAME_START), .oBUF_ACTIVE(oBUF_ACTIVE)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Reference model state
    int          mh, mv, mp, last_addr, prev_addr;
    logic        mbuf, m_cur_en, first_cyc;
    int          m_cx, m_cy;
    logic [23:0] m_ccol;
    logic [23:0] pal_m [256];
    logic        pv_valid, pv_vis, pv_hit, pv_hs, pv_vs;
    logic        mem_mode;
    logic        coll_armed, coll_done, coll_check, coll_new_check, coll_new_seen;
    int          white_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input int addr);
        return mem_mode ? 8'(3 + addr % 6) : 8'd5;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mp = 0; last_addr = 0; prev_addr = 0;
        mbuf = 1'b0; m_cur_en = 1'b0; m_cx = 0; m_cy = 0; m_ccol = '0;
        pv_valid = 1'b0; pv_vis = 1'b0; pv_hit = 1'b0; pv_hs = 1'b1; pv_vs = 1'b1;
        first_cyc = 1'b1;
        sb_q.delete();
    endtask

    // One pixel clock of model: compare due outputs, drive memory data, push next expectation
    task automatic evaluate();
        exp_t       e;
        int         exp_addr;
        logic       vis;
        logic [7:0] idx;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("pixel", 32'({oHS, oVS, oBLANK_n, b_data, g_data, r_data}), 32'(e));
        end
        if (coll_check) begin
            check_eq("collision_old", 32'({b_data, g_data, r_data}), 32'h00FF00);
            coll_check = 1'b0;
        end
        if (coll_new_check) begin
            check_eq("collision_new", 32'({b_data, g_data, r_data}), 32'h0000FF);
            coll_new_check = 1'b0;
        end
        vis      = (mh < 8) && (mv < 4);
        exp_addr = vis ? ((mbuf ? 32 : 0) + mp) : last_addr;
        check_eq("fb_addr", 32'(oFB_ADDR), 32'(exp_addr));
        check_eq("frame_start", 32'(oFRAME_START), 32'(mh == 0 && mv == 0 && !first_cyc));
        check_eq("buf_active", 32'(oBUF_ACTIVE), 32'(mbuf));

        idx      = pv_valid ? mem_rd(prev_addr) : 8'd0;
        iFB_DATA = idx;
        if (!pv_valid) begin
            e = exp_t'({1'b1, 1'b1, 1'b0, 24'd0});
        end else begin
            e.hs    = pv_hs;
            e.vs    = pv_vs;
            e.blank = pv_vis;
            e.rgb   = !pv_vis ? 24'd0 : (pv_hit ? m_ccol : pal_m[idx]);
        end
        sb_q.push_back(e);

        iPAL_WE = 1'b0;
        if (pv_valid && pv_vis && !pv_hit && idx == 8'd5) begin
            if (coll_armed) begin
                iPAL_WE = 1'b1; iPAL_ADDR = 8'd5; iPAL_DATA = 24'h0000FF;
                coll_armed = 1'b0; coll_done = 1'b1; coll_check = 1'b1;
            end else if (coll_done && !coll_new_seen) begin
                coll_new_seen = 1'b1; coll_new_check = 1'b1;
            end
        end
        if (iPAL_WE) pal_m[iPAL_ADDR] = iPAL_DATA;

        pv_valid = 1'b1;
        pv_vis   = vis;
        pv_hit   = m_cur_en && mh >= m_cx && mh < m_cx + 2 && mv >= m_cy && mv < m_cy + 2;
        pv_hs    = !(mh >= 10 && mh < 12);
        pv_vs    = !(mv == 5);
        prev_addr = exp_addr;
        if (vis) begin
            last_addr = exp_addr;
            mp++;
        end
        if (mh == 13 && mv == 6) begin
            mbuf = iBUF_SEL; m_cur_en = iCUR_EN; m_cx = int'(iCUR_X); m_cy = int'(iCUR_Y);
            m_ccol = iCUR_COLOR; mp = 0;
        end
        if (mh == 13) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        first_cyc = 1'b0;
    endtask

    task automatic step();
        if (oBLANK_n && {b_data, g_data, r_data} == 24'hFFFFFF) white_cnt++;
        evaluate();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_fs(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (oFRAME_START === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int blank_cnt, hs_low, vs_low, fs_cnt, first_blank, first_hs;
        logic found;
        iRST_n = 1'b0; iPAL_WE = 1'b0; iPAL_ADDR = '0; iPAL_DATA = '0;
        iBUF_SEL = 1'b0; iCUR_EN = 1'b0; iCUR_X = '0; iCUR_Y = '0; iCUR_COLOR = '0;
        iFB_DATA = '0; mem_mode = 1'b0; white_cnt = 0;
        coll_armed = 1'b0; coll_done = 1'b0; coll_check = 1'b0;
        coll_new_check = 1'b0; coll_new_seen = 1'b0;
        model_reset();

        // Palette is not reset, so load every entry while held in reset
        @(posedge clk); #1;
        for (int i = 0; i < 257; i++) begin
            iPAL_WE   = 1'b1;
            iPAL_ADDR = (i == 256) ? 8'd5 : 8'(i);
            iPAL_DATA = (i == 256) ? 24'h00FF00 : {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
            pal_m[iPAL_ADDR] = iPAL_DATA;
            @(posedge clk); #1;
        end
        iPAL_WE = 1'b0;

        check_eq("rst_hs", 32'(oHS), 32'd1);
        check_eq("rst_vs", 32'(oVS), 32'd1);
        check_eq("rst_blank", 32'(oBLANK_n), 32'd0);
        check_eq("rst_rgb", 32'({b_data, g_data, r_data}), 32'd0);
        check_eq("rst_fs", 32'(oFRAME_START), 32'd0);
        check_eq("rst_buf", 32'(oBUF_ACTIVE), 32'd0);
        check_eq("rst_addr", 32'(oFB_ADDR), 32'd0);

        // Three free-running frames with a constant index of 5
        iRST_n = 1'b1;
        cyc = 0;
        blank_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; first_blank = -1; first_hs = -1;
        for (int i = 0; i < 296; i++) begin
            if (i >= 2) begin
                if (oBLANK_n) blank_cnt++;
                if (!oHS) hs_low++;
                if (!oVS) vs_low++;
                if (oFRAME_START) fs_cnt++;
                if (oBLANK_n && first_blank < 0) first_blank = i;
                if (!oHS && first_hs < 0) first_hs = i;
            end
            step();
        end
        check_eq("blank_high_clocks", 32'(blank_cnt), 32'd96);
        check_eq("hs_low_clocks", 32'(hs_low), 32'd42);
        check_eq("vs_low_clocks", 32'(vs_low), 32'd42);
        check_eq("frame_pulses", 32'(fs_cnt), 32'd3);
        check_eq("first_visible_out", 32'(first_blank), 32'd2);
        check_eq("first_hs_low", 32'(first_hs), 32'd12);

        // Varied indices; buffer and cursor requested mid-frame take effect next frame
        mem_mode = 1'b1;
        for (int i = 0; i < 40; i++) step();
        iBUF_SEL = 1'b1; iCUR_EN = 1'b1; iCUR_X = 11'd7; iCUR_Y = 11'd3; iCUR_COLOR = 24'hFFFFFF;
        run_to_fs("fs_timeout_f5");
        check_eq("buf_active_at_fs", 32'(oBUF_ACTIVE), 32'd1);
        white_cnt = 0;
        for (int i = 0; i < 40; i++) step();
        iCUR_X = 11'd2;
        run_to_fs("fs_timeout_f6");
        check_eq("white_pixels_clipped", 32'(white_cnt), 32'd1);
        white_cnt = 0;
        coll_armed = 1'b1;
        run_to_fs("fs_timeout_f7");
        check_eq("white_pixels_moved", 32'(white_cnt), 32'd2);
        check_eq("collision_done", 32'(coll_done && coll_new_seen), 32'd1);

        // Asynchronous reset in the middle of line 2
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mh == 5 && mv == 2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("midline_found", 32'(found), 32'd1);
        iRST_n = 1'b0;
        #1;
        check_eq("arst_hs", 32'(oHS), 32'd1);
        check_eq("arst_vs", 32'(oVS), 32'd1);
        check_eq("arst_blank", 32'(oBLANK_n), 32'd0);
        check_eq("arst_rgb", 32'({b_data, g_data, r_data}), 32'd0);
        check_eq("arst_fs", 32'(oFRAME_START), 32'd0);
        check_eq("arst_buf", 32'(oBUF_ACTIVE), 32'd0);
        check_eq("arst_addr", 32'(oFB_ADDR), 32'd0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        iRST_n = 1'b1;
        cyc = 0;
        check_eq("release_addr", 32'(oFB_ADDR), 32'd0);
        run_to_fs("fs_timeout_after_reset");
        check_eq("fs_after_release", 32'(cyc), 32'd98);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
